// File: rtl/ets_buffer_reader.sv
// ets_buffer_reader
// Drains the ETS sample buffer through its AXI4-Lite data-window slave port.
// Each word is forwarded on an AXI4-Stream output. Only one read is
// outstanding at a time, and a word stays in the holding register until the
// stream sink takes it. All outputs come straight from flops, so no input
// has a combinational path to any output.

module ets_buffer_reader #(
    parameter int C_M_AXI_ADDR_WIDTH = 11,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int CNT_WIDTH          = 10
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,

    input  logic                          start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]          word_count,
    output logic                          busy,
    output logic                          done,
    output logic                          error,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        PUSH,
        FIN
    } state_t;

    state_t                          state_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [CNT_WIDTH-1:0]            remaining_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   holdData_q;
    logic                            holdLast_q;
    logic                            arValid_q;
    logic                            rReady_q;
    logic                            tValid_q;
    logic                            busy_q;
    logic                            done_q;
    logic                            error_q;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   addrStart_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addrStep_d;
    logic [CNT_WIDTH-1:0]            remainingDec_d;
    logic                            lastWord_d;
    logic                            moreWords_d;
    logic [1:0]                      unusedBaseLsbs;

    // The window is word addressed: the byte-lane bits of base_addr are dropped.
    assign unusedBaseLsbs = base_addr[1:0];

    // Next values for the address and word counter. The address wraps silently
    // at the top of the window.
    always_comb begin
        addrStart_d    = {base_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
        addrStep_d     = addr_q + C_M_AXI_ADDR_WIDTH'(4);
        remainingDec_d = remaining_q - CNT_WIDTH'(1);
        lastWord_d     = (remaining_q == CNT_WIDTH'(1));
        moreWords_d    = (remaining_q > CNT_WIDTH'(1));
    end

    // Drain sequencer; every interface output is registered here alongside the state.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            holdData_q  <= '0;
            holdLast_q  <= 1'b0;
            arValid_q   <= 1'b0;
            rReady_q    <= 1'b0;
            tValid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (word_count != '0) begin
                            addr_q      <= addrStart_d;
                            remaining_q <= word_count;
                            arValid_q   <= 1'b1;
                            state_q     <= ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end

                ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arValid_q <= 1'b0;
                        rReady_q  <= 1'b1;
                        state_q   <= DATA;
                    end
                end

                DATA: begin
                    if (M_AXI_RVALID) begin
                        rReady_q   <= 1'b0;
                        holdData_q <= M_AXI_RDATA;
                        holdLast_q <= lastWord_d;
                        tValid_q   <= 1'b1;
                        if (M_AXI_RRESP != 2'b00) begin
                            error_q <= 1'b1;
                        end
                        state_q <= PUSH;
                    end
                end

                PUSH: begin
                    if (m_axis_tready) begin
                        tValid_q    <= 1'b0;
                        holdLast_q  <= 1'b0;
                        remaining_q <= remainingDec_d;
                        addr_q      <= addrStep_d;
                        if (moreWords_d) begin
                            arValid_q <= 1'b1;
                            state_q   <= ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end

                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arValid_q;
    assign M_AXI_RREADY  = rReady_q;
    assign m_axis_tdata  = holdData_q;
    assign m_axis_tvalid = tValid_q;
    assign m_axis_tlast  = holdLast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_ets_buffer_reader.sv
// Testbench for ets_buffer_reader.
// A behavioural AXI-Lite slave and a stream sink run in one monitor loop.
// Every accepted read address pushes the expected word onto a scoreboard,
// and every stream handshake pops it back off for comparison.

module tb_ets_buffer_reader;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int CW = 10;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } expWord_t;

    logic          clk = 1'b0;
    logic          M_AXI_ARESETN;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [2:0]    M_AXI_ARPROT;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY;
    logic [DW-1:0] M_AXI_RDATA;
    logic [1:0]    M_AXI_RRESP;
    logic          M_AXI_RVALID;
    logic          M_AXI_RREADY;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    int testCount = 0;
    int failCount = 0;

    expWord_t sbQueue[$];

    int            edgeCnt = 0;
    int            doneCnt = 0;
    int            doneEdge = 0;
    logic          busyAtDone = 1'b0;
    int            arIdx = 0;
    int            pendIdx = 0;
    int            acceptedCnt = 0;
    int            arvalidCycles = 0;
    int            busyCycles = 0;
    int            arWait = 0;
    int            rWait = 0;
    int            stallDone = 0;
    int            errIdx = -1;
    int            stallIdx = -1;
    int            stallLen = 0;
    bit            rndDelays = 1'b0;
    logic [7:0]    curTag = 8'h00;
    logic [AW-1:0] drainBase = '0;
    logic [CW-1:0] drainCount = '0;
    logic [AW-1:0] rAddr = '0;
    logic [AW-1:0] expAddr;
    bit            rPending = 1'b0;
    logic          rOutstanding = 1'b0;
    logic          expErr = 1'b0;

    logic          arValidSeen = 1'b0;
    logic [AW-1:0] arAddrSeen = '0;
    logic          rReadySeen = 1'b0;
    logic          tvalidSeen = 1'b0;
    logic [DW-1:0] tdataSeen = '0;
    logic          tlastSeen = 1'b0;
    logic          busySeen = 1'b0;
    logic          doneSeen = 1'b0;

    ets_buffer_reader #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .CNT_WIDTH(CW)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESETN(M_AXI_ARESETN),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .busy(busy),
        .done(done),
        .error(error),
        .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    // Contents of the sample buffer as seen through the data window.
    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        return (32'(curTag) << 24) | (32'h0000_00A0 + 32'(a[AW-1:2]));
    endfunction

    function automatic int pickDelay();
        return rndDelays ? int'($urandom_range(5, 0)) : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_arvalid", M_AXI_ARVALID, 0);
        checkOutput("rst_rready", M_AXI_RREADY, 0);
        checkOutput("rst_tvalid", m_axis_tvalid, 0);
        checkOutput("rst_tlast", m_axis_tlast, 0);
        checkOutput("rst_araddr", M_AXI_ARADDR, 0);
        checkOutput("rst_tdata", m_axis_tdata, 0);
        checkOutput("arprot", M_AXI_ARPROT, 0);
    endtask

    // Slave, sink and scoreboard: sampled 1 ns after each rising edge, once the
    // registered DUT outputs have settled.
    initial begin
        forever begin
            @(posedge clk);
            edgeCnt++;
            #1;
            if (!M_AXI_ARESETN) begin
                sbQueue.delete();
                rPending      = 1'b0;
                rOutstanding  = 1'b0;
                expErr        = 1'b0;
                M_AXI_ARREADY = 1'b0;
                M_AXI_RVALID  = 1'b0;
                m_axis_tready = 1'b1;
            end else begin
                if (start && !busySeen) begin
                    drainBase     = base_addr;
                    drainCount    = word_count;
                    arIdx         = 0;
                    acceptedCnt   = 0;
                    arvalidCycles = 0;
                    busyCycles    = 0;
                    stallDone     = 0;
                    expErr        = 1'b0;
                    arWait        = pickDelay();
                end
                if (M_AXI_ARREADY && arValidSeen) begin
                    expAddr = {drainBase[AW-1:2], 2'b00} + AW'(4 * arIdx);
                    checkOutput("araddr", arAddrSeen, expAddr);
                    sbQueue.push_back('{data: memWord(expAddr), last: (arIdx == int'(drainCount) - 1)});
                    rAddr         = arAddrSeen;
                    pendIdx       = arIdx;
                    arIdx++;
                    rPending      = 1'b1;
                    rOutstanding  = 1'b1;
                    rWait         = pickDelay();
                    arWait        = pickDelay();
                    M_AXI_ARREADY = 1'b0;
                end
                if (M_AXI_RVALID && rReadySeen) begin
                    if (M_AXI_RRESP != 2'b00) expErr = 1'b1;
                    rOutstanding = 1'b0;
                    M_AXI_RVALID = 1'b0;
                    M_AXI_RDATA  = $urandom;
                end
                if (m_axis_tready && tvalidSeen) begin
                    if (sbQueue.size() == 0) begin
                        checkOutput("sb_nonempty", 0, 1);
                    end else begin
                        expWord_t e;
                        e = sbQueue.pop_front();
                        checkOutput("tdata", tdataSeen, e.data);
                        checkOutput("tlast", tlastSeen, e.last);
                    end
                    acceptedCnt++;
                end else if (tvalidSeen) begin
                    checkOutput("tvalid_hold", m_axis_tvalid, 1);
                    checkOutput("tdata_hold", m_axis_tdata, tdataSeen);
                    checkOutput("tlast_hold", m_axis_tlast, tlastSeen);
                end
                if (M_AXI_ARVALID && !M_AXI_ARREADY) begin
                    if (arWait == 0) M_AXI_ARREADY = 1'b1;
                    else arWait--;
                end
                if (rPending) begin
                    if (rWait == 0) begin
                        M_AXI_RVALID = 1'b1;
                        M_AXI_RDATA  = memWord(rAddr);
                        M_AXI_RRESP  = (pendIdx == errIdx) ? 2'b10 : 2'b00;
                        rPending     = 1'b0;
                    end else begin
                        rWait--;
                    end
                end
                if (m_axis_tvalid && acceptedCnt == stallIdx && stallDone < stallLen) begin
                    m_axis_tready = 1'b0;
                    stallDone++;
                end else begin
                    m_axis_tready = 1'b1;
                end
                checkOutput("rready_window", M_AXI_RREADY, rOutstanding);
                checkOutput("error_flag", error, expErr);
                if (M_AXI_ARVALID) arvalidCycles++;
                if (busy) busyCycles++;
                if (done) begin
                    checkOutput("done_width", doneSeen, 0);
                    doneEdge   = edgeCnt;
                    busyAtDone = busy;
                    doneCnt++;
                end
            end
            arValidSeen = M_AXI_ARVALID;
            arAddrSeen  = M_AXI_ARADDR;
            rReadySeen  = M_AXI_RREADY;
            tvalidSeen  = m_axis_tvalid;
            tdataSeen   = m_axis_tdata;
            tlastSeen   = m_axis_tlast;
            busySeen    = busy;
            doneSeen    = done;
        end
    end

    // One complete drain: pulse start, wait (bounded) for done, then check the totals.
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [CW-1:0] count,
                                 input int errAt, input int stallAt, input int stallFor,
                                 input bit rnd, input bit poke, input logic expErrEnd);
        int k;
        int doneBefore;
        bit timedOut;
        errIdx    = errAt;
        stallIdx  = stallAt;
        stallLen  = stallFor;
        rndDelays = rnd;
        curTag    = curTag + 8'h01;
        @(posedge clk); #2;
        doneBefore = doneCnt;
        start      = 1'b1;
        base_addr  = base;
        word_count = count;
        k          = edgeCnt + 1;
        @(posedge clk); #2;
        start      = 1'b0;
        base_addr  = AW'($urandom);
        word_count = CW'($urandom);
        timedOut   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (doneCnt != doneBefore) begin
                timedOut = 1'b0;
                break;
            end
            if (poke) start = (i >= 1 && i <= 8 && (i % 2) == 1);
            @(posedge clk); #2;
        end
        start = 1'b0;
        checkOutput("done_timeout", timedOut, 0);
        if (!rnd && stallAt < 0) checkOutput("done_cycle", doneEdge - k, 3 * int'(count));
        checkOutput("busy_at_done", busyAtDone, 1);
        checkOutput("word_total", acceptedCnt, int'(count));
        checkOutput("sb_left", sbQueue.size(), 0);
        checkOutput("error_end", error, expErrEnd);
        @(posedge clk); #2;
        checkOutput("busy_idle", busy, 0);
        checkOutput("done_low", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence.
    initial begin
        bit reached;
        M_AXI_ARESETN = 1'b0;
        start         = 1'b0;
        base_addr     = '0;
        word_count    = '0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = 2'b00;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkIdleOutputs();
        M_AXI_ARESETN = 1'b1;

        $display("[TB] basic drain base 0x000 count 4");
        applyStimulus(11'h000, 10'd4, -1, -1, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] wrap base 0x7F8 count 3");
        applyStimulus(11'h7F8, 10'd3, -1, -1, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] backpressure base 0x103 count 8");
        applyStimulus(11'h103, 10'd8, -1, 1, 7, 1'b1, 1'b0, 1'b0);

        $display("[TB] error response on word 1 of 3");
        applyStimulus(11'h040, 10'd3, 1, -1, 0, 1'b0, 1'b0, 1'b1);

        $display("[TB] next start clears error");
        applyStimulus(11'h080, 10'd2, -1, -1, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] zero count");
        applyStimulus(11'h020, 10'd0, -1, -1, 0, 1'b0, 1'b0, 1'b0);
        checkOutput("zero_arvalid", arvalidCycles, 0);
        checkOutput("zero_busy_cycles", busyCycles, 1);

        $display("[TB] start pulses while busy");
        applyStimulus(11'h200, 10'd5, -1, -1, 0, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset during word 2");
        errIdx    = -1;
        stallIdx  = -1;
        rndDelays = 1'b0;
        curTag    = curTag + 8'h01;
        @(posedge clk); #2;
        start      = 1'b1;
        base_addr  = 11'h300;
        word_count = 10'd4;
        @(posedge clk); #2;
        start   = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (arIdx == 2 && M_AXI_RREADY) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        checkOutput("reach_word2_data", reached, 1);
        M_AXI_ARESETN = 1'b0;
        @(posedge clk); #2;
        checkIdleOutputs();
        M_AXI_ARESETN = 1'b1;
        repeat (3) begin
            @(posedge clk); #2;
            checkOutput("no_done_after_rst", done, 0);
        end
        applyStimulus(11'h010, 10'd2, -1, -1, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
